note_lane_shifter: RTL
======================

NOTE_LANE_SHIFTER -- requirements
Module: note_lane_shifter

Parameters
REQ-001 SHALL provide parameter STEP_DIV, default 2500000; clk cycles per lane step, minimum 2.
REQ-002 SHALL provide parameter LANE_LEN, fixed 16; number of lane cells, cell 15 = entry, cell 0 = exit.

Interface
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-low (asserted when 0, sampled on rising clk).
REQ-005 run  in  1  1 = step counter advances; 0 = lane frozen.
REQ-006 spawn_valid  in  1  chart source offers a note.
REQ-007 spawn_color  in  1  0 = red note, 1 = blue note; meaningful only with spawn_valid.
REQ-008 spawn_ready  out  1  pending slot empty; a note transfers when spawn_valid & spawn_ready.
REQ-009 delete_note  in  1  one-cycle request from the judge to remove the head note.
REQ-010 offset  out  3  head-note position code in the judge window, 0 = no note in window.
REQ-011 node_R  out  1  head note in window is red.
REQ-012 node_B  out  1  head note in window is blue.
REQ-013 lane_red  out  16  bit i = cell i holds a red note (display).
REQ-014 lane_blue  out  16  bit i = cell i holds a blue note (display).
REQ-015 miss  out  1  one-cycle pulse when an unjudged note leaves the window.
REQ-016 miss_count  out  8  saturating count of misses.

Function
REQ-017 Each cell SHALL hold one of: empty, red, blue; red and blue bits of a cell are never both 1.
REQ-018 Step counter SHALL count 0..STEP_DIV-1 while run=1 and hold while run=0; step tick asserts in the cycle the counter equals STEP_DIV-1, and the counter wraps to 0.
REQ-019 On a step tick: cell i <= cell i+1 for i=0..14; cell 15 <= pending note if pending valid, else empty; pending cleared.
REQ-020 Pending slot: one entry; spawn_ready = ~pending_valid; accepted note stored next edge; an accept in a step-tick cycle lands in pending, not cell 15.
REQ-021 Judge window = cells 1..5; head = lowest-index occupied cell in 1..5.
REQ-022 offset SHALL be 6 - head index (cell 5 -> 1 early, cells 4/3/2 -> 2/3/4 perfect, cell 1 -> 5 late); 0 when window empty.
REQ-023 offset, node_R and node_B SHALL be combinational from current cell state; node_R/node_B both 0 when offset=0.
REQ-024 delete_note=1 SHALL clear the head cell as evaluated on pre-edge state; no effect if window empty.
REQ-025 delete_note and step tick in the same cycle: delete applies first, then the shift; a note deleted in cell 1 SHALL NOT generate miss.
REQ-026 miss SHALL pulse for exactly the cycle following a step tick that moved an occupied, undeleted cell 1 into cell 0.
REQ-027 miss_count SHALL increment on each miss pulse and saturate at 255.
REQ-028 Cell 0 contents are discarded on the next step tick; cell 0 is outside the window and not deletable.
REQ-029 run=0 SHALL NOT block spawn acceptance into pending or delete_note.

Reset
REQ-030 rst=0 at a rising edge SHALL clear all cells, pending slot, step counter, miss and miss_count; spawn_ready=1, offset=0, node_R=node_B=0, lane_red=lane_blue=0.
REQ-031 Reset mid-operation SHALL override any same-cycle step, spawn or delete.

Verification (STEP_DIV=4)
REQ-032 Reset, run=1, spawn red once -> spawn_ready low 1 cycle-window until next tick; after tick lane_red=16'h8000; after 10 more ticks lane_red=16'h0020, offset=1, node_R=1.
REQ-033 Red note reaches cell 3 -> offset=3; pulse delete_note -> next edge lane_red=0, offset=0, no miss thereafter.
REQ-034 Blue note left unjudged -> after passing cell 1, miss pulses one cycle, miss_count=1; lane_blue=16'h0001 until next tick, then 0.
REQ-035 Red at cell 2, blue at cell 4 -> offset=4, node_R=1, node_B=0; delete -> offset=2, node_B=1.
REQ-036 Note in cell 1, delete_note on tick cycle -> no miss, miss_count unchanged; run=0 for 20 cycles -> lane unchanged.
REQ-037 300 unjudged notes -> miss_count=255; rst=0 mid-run -> all outputs at reset values next edge.

Source files
------------

// File: rtl/note_lane_shifter.sv
// rtl/note_lane_shifter.sv - 16-cell red/blue note lane with pending spawn slot,
// judge window on cells 1..5, delete-before-shift ordering and saturating miss count.
module note_lane_shifter #(
   parameter int STEP_DIV = 2500000,
   parameter int LANE_LEN = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                spawn_valid,
   input  logic                spawn_color,
   output logic                spawn_ready,
   input  logic                delete_note,
   output logic [2:0]          offset,
   output logic                node_R,
   output logic                node_B,
   output logic [LANE_LEN-1:0] lane_red,
   output logic [LANE_LEN-1:0] lane_blue,
   output logic                miss,
   output logic [7:0]          miss_count
);

   localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [LANE_LEN-1:0] red_q, red_d;
   logic [LANE_LEN-1:0] blue_q, blue_d;
   logic                pend_valid_q, pend_valid_d;
   logic                pend_color_q, pend_color_d;
   logic                miss_q, miss_d;
   logic [7:0]          miss_count_q, miss_count_d;

   logic                tick;
   logic                accept;
   logic                head_found;
   logic [2:0]          head_idx;
   logic [LANE_LEN-1:0] red_del;
   logic [LANE_LEN-1:0] blue_del;

   // Head = lowest occupied cell in the judge window (cells 1..5).
   always_comb begin
      head_found = 1'b0;
      head_idx   = 3'd0;
      for (int i = 1; i <= 5; i++) begin
         if (!head_found && (red_q[i] || blue_q[i])) begin
            head_found = 1'b1;
            head_idx   = 3'(i);
         end
      end
   end

   always_comb begin
      offset = 3'd0;
      node_R = 1'b0;
      node_B = 1'b0;
      if (head_found) begin
         offset = 3'd6 - head_idx;
         node_R = red_q[head_idx];
         node_B = blue_q[head_idx];
      end
   end

   assign tick   = run && (cnt_q == CNT_MAX);
   assign accept = spawn_valid && !pend_valid_q;

   always_comb begin
      cnt_d = cnt_q;
      if (run) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // The delete is applied to the pre-edge image first, so a shift in the
   // same cycle moves the already-cleared lane and cannot report a miss.
   always_comb begin
      red_del  = red_q;
      blue_del = blue_q;
      if (delete_note && head_found) begin
         red_del[head_idx]  = 1'b0;
         blue_del[head_idx] = 1'b0;
      end
   end

   always_comb begin
      red_d  = red_del;
      blue_d = blue_del;
      miss_d = 1'b0;
      if (tick) begin
         red_d  = {pend_valid_q && !pend_color_q, red_del[LANE_LEN-1:1]};
         blue_d = {pend_valid_q &&  pend_color_q, blue_del[LANE_LEN-1:1]};
         miss_d = red_del[1] || blue_del[1];
      end
   end

   // A spawn accepted in a tick cycle lands in the slot the tick just emptied.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_color_d = pend_color_q;
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_color_d = spawn_color;
      end else if (tick) begin
         pend_valid_d = 1'b0;
      end
   end

   always_comb begin
      miss_count_d = miss_count_q;
      if (miss_d && (miss_count_q != 8'hff)) begin
         miss_count_d = miss_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q        <= '0;
         red_q        <= '0;
         blue_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_color_q <= 1'b0;
         miss_q       <= 1'b0;
         miss_count_q <= 8'd0;
      end else begin
         cnt_q        <= cnt_d;
         red_q        <= red_d;
         blue_q       <= blue_d;
         pend_valid_q <= pend_valid_d;
         pend_color_q <= pend_color_d;
         miss_q       <= miss_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign spawn_ready = !pend_valid_q;
   assign lane_red    = red_q;
   assign lane_blue   = blue_q;
   assign miss        = miss_q;
   assign miss_count  = miss_count_q;

endmodule
